// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    // Fetch FSM: REQ issues a request, WAIT expects a word to keep,
    // DISCARD expects a word made stale by a redirect.
    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage : fetch_pkg

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO of fetched instructions feeding decode.
// A flush empties it and overrides any same-cycle push or pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     entry_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_next_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Occupancy after this cycle's push/pop/flush; also exported for credit.
    always_comb begin
        if (flush_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Storage write port.
    // NOTE: the entry array is deliberately not reset; head_o is masked to
    // zero whenever the queue is empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    // Pointer and count bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    assign head_o       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one memory request in
// flight, buffers returned words for decode and handles execute redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int               CNT_W   = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             req_valid_q, req_valid_d;

    logic             req_fire;
    logic             q_push;
    logic             q_pop;
    fetch_entry_t     q_entry;
    fetch_entry_t     q_head;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] q_count_next;

    assign req_fire = req_valid_q && imem_req_ready;
    assign q_push   = (state_q == WAIT) && imem_resp_valid;
    assign q_pop    = instr_valid && instr_ready;
    assign q_entry  = '{pc: req_pc_q, instr: imem_resp_data};

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (q_push),
        .pop_i        (q_pop),
        .flush_i      (redirect_valid),
        .entry_i      (q_entry),
        .head_o       (q_head),
        .count_o      (q_count),
        .count_next_o (q_count_next)
    );

    // Next-state logic: normal fetch sequencing, then redirect override.
    // NOTE: every variable gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;

        unique case (state_q)
            REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_STEP;
                    state_d  = WAIT;
                end
            end
            WAIT, DISCARD: begin
                if (imem_resp_valid) state_d = REQ;
            end
            default: state_d = REQ;
        endcase

        // A redirect keeps the new PC un-incremented; any request already
        // accepted (or accepted this cycle) must have its word thrown away.
        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'h3;
            if (state_q == REQ) begin
                state_d = req_fire ? DISCARD : REQ;
            end else begin
                state_d = imem_resp_valid ? REQ : DISCARD;
            end
        end

        // Only REQ has nothing outstanding, so credit reduces to queue room.
        req_valid_d = (state_d == REQ) && (q_count_next < DEPTH_C);
    end

    // FSM, PC and registered request-valid.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign instr_valid    = (q_count != '0);
    assign instr          = q_head.instr;
    assign instr_pc       = q_head.pc;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int checks = 0;
    int errors = 0;

    // Memory model knobs (written by the stimulus block only).
    int mem_lat   = 1;
    int stray_req = 0;

    // Memory model state (written by the responder only).
    logic        mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    int          stray_done = 0;

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc)
    );

    always #5 clk = ~clk;

    // Memory responder on the falling edge: returns addr^FFFF_FFFF mem_lat
    // cycles after each accepted request, or a one-off stray word on demand.
    always @(negedge clk) begin
        if (!rst_n) begin
            imem_resp_valid = 1'b0;
            mem_pend        = 1'b0;
        end else begin
            imem_resp_valid = 1'b0;
            if (mem_pend) begin
                if (mem_cnt <= 1) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_addr ^ 32'hFFFF_FFFF;
                    mem_pend        = 1'b0;
                end else begin
                    mem_cnt = mem_cnt - 1;
                end
            end else if (stray_done != stray_req) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = 32'hDEAD_BEEF;
                stray_done      = stray_req;
            end
            if (imem_req_valid && imem_req_ready) begin
                mem_pend = 1'b1;
                mem_cnt  = mem_lat;
                mem_addr = imem_req_addr;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- Reset state ----
        tick();
        tick();
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        rst_n = 1'b1;

        // ---- Streaming with 1-cycle memory ----
        tick(); // c1
        check("t1_c1_req_valid", 32'(imem_req_valid), 32'd1);
        check("t1_c1_req_addr", imem_req_addr, 32'h0);
        check("t1_c1_instr_valid", 32'(instr_valid), 32'd0);
        tick(); // c2
        check("t1_c2_req_valid", 32'(imem_req_valid), 32'd0);
        tick(); // c3
        check("t1_c3_instr_valid", 32'(instr_valid), 32'd1);
        check("t1_c3_instr_pc", instr_pc, 32'h0);
        check("t1_c3_instr", instr, 32'hFFFF_FFFF);
        check("t1_c3_req_addr", imem_req_addr, 32'h4);
        check("t1_c3_req_valid", 32'(imem_req_valid), 32'd1);
        tick(); // c4
        check("t1_c4_instr_valid", 32'(instr_valid), 32'd0);
        tick(); // c5
        check("t1_c5_instr_pc", instr_pc, 32'h4);
        check("t1_c5_instr", instr, 32'hFFFF_FFFB);
        check("t1_c5_req_addr", imem_req_addr, 32'h8);
        tick(); // c6
        check("t1_c6_instr_valid", 32'(instr_valid), 32'd0);
        tick(); // c7
        check("t1_c7_instr_pc", instr_pc, 32'h8);
        check("t1_c7_instr", instr, 32'hFFFF_FFF7);
        check("t1_c7_req_addr", imem_req_addr, 32'hC);
        check("t1_c7_req_valid", 32'(imem_req_valid), 32'd1);

        // ---- Redirect coinciding with the handshake for 0xC ----
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick(); // c8
        redirect_valid = 1'b0;
        check("t4_c8_req_valid", 32'(imem_req_valid), 32'd0);
        check("t4_c8_instr_valid", 32'(instr_valid), 32'd0);
        tick(); // c9
        check("t4_c9_req_valid", 32'(imem_req_valid), 32'd1);
        check("t4_c9_req_addr", imem_req_addr, 32'h200);
        check("t4_c9_instr_valid", 32'(instr_valid), 32'd0);
        tick(); // c10
        check("t4_c10_instr_valid", 32'(instr_valid), 32'd0);
        tick(); // c11
        check("t4_c11_instr_pc", instr_pc, 32'h200);
        check("t4_c11_instr", instr, 32'hFFFF_FDFF);
        instr_ready = 1'b0;
        tick(); // c12: waiting on 0x204 with one entry queued
        check("t5_pre_instr_valid", 32'(instr_valid), 32'd1);
        check("t5_pre_req_addr", imem_req_addr, 32'h208);

        // ---- Asynchronous reset mid-WAIT ----
        rst_n = 1'b0;
        #1;
        check("t5_async_instr_valid", 32'(instr_valid), 32'd0);
        check("t5_async_instr_pc", instr_pc, 32'h0);
        check("t5_async_req_valid", 32'(imem_req_valid), 32'd0);
        check("t5_async_req_addr", imem_req_addr, 32'h0);
        tick();
        tick();
        rst_n     = 1'b1;
        stray_req = stray_req + 1;

        // ---- Decode stalled: queue fills, then drains ----
        tick(); // c1
        check("t2_c1_req_valid", 32'(imem_req_valid), 32'd1);
        check("t2_c1_req_addr", imem_req_addr, 32'h0);
        tick(); // c2
        check("t2_c2_stray_ignored", 32'(instr_valid), 32'd0);
        tick(); // c3
        check("t2_c3_instr_pc", instr_pc, 32'h0);
        check("t2_c3_req_addr", imem_req_addr, 32'h4);
        tick(); // c4
        tick(); // c5
        check("t2_c5_req_valid", 32'(imem_req_valid), 32'd0);
        tick(); // c6
        check("t2_c6_req_valid", 32'(imem_req_valid), 32'd0);
        tick(); // c7
        check("t2_c7_req_valid", 32'(imem_req_valid), 32'd0);
        check("t2_c7_instr_pc", instr_pc, 32'h0);
        check("t2_c7_instr", instr, 32'hFFFF_FFFF);
        instr_ready = 1'b1;
        tick(); // c8
        check("t2_c8_instr_pc", instr_pc, 32'h4);
        check("t2_c8_instr", instr, 32'hFFFF_FFFB);
        check("t2_c8_req_valid", 32'(imem_req_valid), 32'd1);
        check("t2_c8_req_addr", imem_req_addr, 32'h8);
        instr_ready = 1'b0;
        mem_lat     = 3;

        // ---- Redirect to 0x103 while waiting on 0x8 ----
        tick(); // c9
        check("t3_c9_instr_pc", instr_pc, 32'h4);
        check("t3_c9_req_valid", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick(); // c10
        redirect_valid = 1'b0;
        check("t3_c10_flushed", 32'(instr_valid), 32'd0);
        check("t3_c10_instr_pc", instr_pc, 32'h0);
        check("t3_c10_req_valid", 32'(imem_req_valid), 32'd0);
        tick(); // c11
        check("t3_c11_req_valid", 32'(imem_req_valid), 32'd0);
        tick(); // c12
        check("t3_c12_req_valid", 32'(imem_req_valid), 32'd1);
        check("t3_c12_req_addr", imem_req_addr, 32'h100);
        check("t3_c12_late_dropped", 32'(instr_valid), 32'd0);
        instr_ready = 1'b1;
        mem_lat     = 1;
        tick(); // c13
        tick(); // c14
        check("t3_c14_instr_pc", instr_pc, 32'h100);
        check("t3_c14_instr", instr, 32'hFFFF_FEFF);
        check("t3_c14_req_addr", imem_req_addr, 32'h104);

        // ---- PC wrap at 0xFFFF_FFFC ----
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick(); // c15
        redirect_valid = 1'b0;
        check("t6_c15_req_valid", 32'(imem_req_valid), 32'd0);
        check("t6_c15_instr_valid", 32'(instr_valid), 32'd0);
        tick(); // c16
        check("t6_c16_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        check("t6_c16_req_valid", 32'(imem_req_valid), 32'd1);
        tick(); // c17
        tick(); // c18
        check("t6_c18_instr_pc", instr_pc, 32'hFFFF_FFFC);
        check("t6_c18_instr", instr, 32'h0000_0003);
        check("t6_c18_wrap_addr", imem_req_addr, 32'h0);
        check("t6_c18_req_valid", 32'(imem_req_valid), 32'd1);

        // ---- Request held stable while memory stalls ----
        imem_req_ready = 1'b0;
        tick(); // c19
        check("stall_c19_req_valid", 32'(imem_req_valid), 32'd1);
        check("stall_c19_req_addr", imem_req_addr, 32'h0);
        check("stall_c19_instr_valid", 32'(instr_valid), 32'd0);
        tick(); // c20
        check("stall_c20_req_valid", 32'(imem_req_valid), 32'd1);
        check("stall_c20_req_addr", imem_req_addr, 32'h0);
        imem_req_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel plus a fixed response channel.
- Buffers returned words with their PCs in a small queue and presents them to decode over a valid/ready handshake.
- Accepts redirects from execute (branch/jump) and flushes all younger work.

Parameters:
- RESET_PC, 32'h0000_0000: PC of the first fetch after reset.
- QUEUE_DEPTH, 2: instruction queue entries, power of two, at least 2.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- imem_req_valid, output, 1: fetch request valid.
- imem_req_ready, input, 1: memory accepts the request this cycle.
- imem_req_addr, output, 32: word-aligned fetch address, bits [1:0]=0.
- imem_resp_valid, input, 1: response word valid. Exactly one response per accepted request, in order, at least 1 cycle after acceptance.
- imem_resp_data, input, 32: returned instruction word.
- redirect_valid, input, 1: flush and restart fetch at redirect_pc.
- redirect_pc, input, 32: new PC; bits [1:0] are ignored and forced to 0.
- instr_valid, output, 1: instr/instr_pc are valid for decode.
- instr_ready, input, 1: decode consumes the head entry this cycle.
- instr, output, 32: instruction word to decode.
- instr_pc, output, 32: PC of instr.

Behaviour:
- Reset (async assert, sync release effect):
  - pc=RESET_PC, state=REQ, queue empty.
  - instr_valid=0, instr=0, instr_pc=0, imem_req_valid=0, imem_req_addr=RESET_PC.
- At most one outstanding memory request.
- A request is issued only when queue_count + outstanding < QUEUE_DEPTH, so the queue can never overflow.
- State machine (fetch_state_t), states REQ, WAIT, DISCARD:
  - REQ:
    - imem_req_valid=1 when credit is available; imem_req_addr=pc.
    - On req_valid&&req_ready: latch req_pc=pc, pc<=pc+4 (mod 2^32, wrap silently), go to WAIT.
  - WAIT:
    - On resp_valid: push {req_pc, resp_data} into the queue, go to REQ.
  - DISCARD:
    - On resp_valid: drop the word, go to REQ.
- Redirect (highest priority, any state):
  - pc<=redirect_pc&~3 and the queue is flushed. A same-cycle pop is ignored and a same-cycle push is dropped.
  - REQ with no handshake that cycle: stay in REQ; the next request uses the new pc.
  - REQ with handshake in the same cycle: go to DISCARD; the new pc is kept and is not incremented.
  - WAIT without resp_valid: go to DISCARD.
  - WAIT with resp_valid: drop the response, go to REQ.
  - DISCARD without resp_valid: stay in DISCARD. With resp_valid: go to REQ.
- Latency:
  - First imem_req_valid appears in the first cycle after rst_n deasserts.
  - Response in cycle N gives instr_valid in cycle N+1 (registered queue, no bypass).
  - Back-to-back throughput is 1 instruction per 2 cycles with 1-cycle memory.
- Decode handshake:
  - instr_valid = queue not empty. instr and instr_pc hold stable while instr_valid&&!instr_ready.
  - Pop on instr_valid&&instr_ready.
  - Push and pop in the same cycle is allowed at any count; count is unchanged.
- Queue indices wrap modulo QUEUE_DEPTH. count ranges 0..QUEUE_DEPTH.
- The request address is held stable while imem_req_valid&&!imem_req_ready, unless a redirect occurs.
- rst_n assertion mid-transaction: all state clears immediately. A response arriving after reset release with no outstanding request is ignored.

Decomposition:
- fetch_pkg holds:
  - typedef fetch_state_t (REQ, WAIT, DISCARD).
  - typedef fetch_entry_t, struct {logic [31:0] pc; logic [31:0] instr;}.
  - localparam INSTR_NOP=32'h0000_0013.
  - localparam PC_STEP=4.
- Sub-module fetch_queue: parametrised FIFO of fetch_entry_t with push, pop, flush, count and head outputs, using the same clk/rst_n.
- fetch_unit holds the pc, the FSM and the credit logic.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning addr^32'hFFFF_FFFF:
  - Requests go to 0x0, 0x4, 0x8.
  - Decode sees (pc=0x0, instr=0xFFFF_FFFF) then (0x4, 0xFFFF_FFFB), in order, each 1 cycle after its response.
- instr_ready=0 held:
  - Exactly 2 words are fetched (0x0, 0x4), then imem_req_valid stays 0.
  - Raising instr_ready drains 0x0 and 0x4, and fetch resumes at 0x8.
- Redirect to 0x103 while in WAIT for 0x8:
  - The late response for 0x8 is dropped and the queue empties.
  - The next request address is 0x100. The next instr_pc seen is 0x100.
- Redirect in the same cycle as the request handshake for 0xC:
  - The FSM enters DISCARD and the 0xC response is not delivered.
  - The next request is at redirect_pc.
- rst_n pulsed low mid-WAIT:
  - Outputs clear asynchronously: instr_valid=0, imem_req_valid=0.
  - A stray resp_valid after release is ignored. The first request is at RESET_PC.
- pc=0xFFFF_FFFC fetched:
  - The next request address wraps to 0x0000_0000.
